// File: rtl/multicycle_core_if.sv
// rtl/multicycle_core_if.sv - instruction and data memory request buses of multicycle_core
interface multicycle_core_if #(
    parameter int XLEN            = 32,
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int DMEM_ADDR_WIDTH = 10
);
    logic                       imem_req;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic                       imem_ready;
    logic [31:0]                imem_rdata;
    logic                       dmem_req;
    logic                       dmem_we;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_addr;
    logic [XLEN-1:0]            dmem_wdata;
    logic                       dmem_ready;
    logic [XLEN-1:0]            dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle RV32I-subset core with valid/ready memory requests
// Optional macro MULTICYCLE_CORE_BRANCH_EXT_EN adds BNE/BLT/BGE/BLTU/BGEU.
module multicycle_core #(
    parameter int              XLEN            = 32,
    parameter int              IMEM_ADDR_WIDTH = 10,
    parameter int              DMEM_ADDR_WIDTH = 10,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              DEBUG_REG       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_core_if.master        mem,
    output logic                     halted,
    output logic                     retire,
    output logic [15:0]              debug
);
    localparam int         SHW     = $clog2(XLEN);
    localparam logic [4:0] DBG_IDX = DEBUG_REG[4:0];

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_plus4;
    logic [31:0]     ir;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q, res_q;
    logic [XLEN-1:0] regs [0:31];

    logic [6:0]      opcode, f7, shift_hi;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic            legal, br_legal, br_taken, is_store;
    logic [XLEN-1:0] imm, alu, alu_a, alu_b;
    logic [2:0]      alu_sel;
    logic            alu_alt;

    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign f3       = ir[14:12];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign f7       = ir[31:25];
    assign is_store = (opcode == OPC_STORE);
    assign pc_plus4 = pc + XLEN'(4);
    // RV64 shift immediates use a 6-bit shamt, so only ir[31:26] is funct
    assign shift_hi = (XLEN == 64) ? {ir[31:26], 1'b0} : ir[31:25];

`ifdef MULTICYCLE_CORE_BRANCH_EXT_EN
    assign br_legal = (f3 != 3'b010) && (f3 != 3'b011);
    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000:  br_taken = (rs1_q == rs2_q);
            3'b001:  br_taken = (rs1_q != rs2_q);
            3'b100:  br_taken = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  br_taken = (rs1_q <  rs2_q);
            3'b111:  br_taken = (rs1_q >= rs2_q);
            default: br_taken = 1'b0;
        endcase
    end
`else
    assign br_legal = (f3 == 3'b000);
    assign br_taken = (rs1_q == rs2_q);
`endif

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_OP:     legal = (f7 == 7'b0000000) ||
                                (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            OPC_IMM: begin
                if (f3 == 3'b001)      legal = (shift_hi == 7'b0000000);
                else if (f3 == 3'b101) legal = (shift_hi == 7'b0000000) ||
                                               (shift_hi == 7'b0100000);
                else                   legal = 1'b1;
            end
            OPC_LOAD:   legal = (f3 == 3'b010);
            OPC_STORE:  legal = (f3 == 3'b010);
            OPC_BRANCH: legal = br_legal;
            OPC_JAL:    legal = 1'b1;
            OPC_LUI:    legal = 1'b1;
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        imm = XLEN'($signed(ir[31:20]));
        case (opcode)
            OPC_STORE:  imm = XLEN'($signed({ir[31:25], ir[11:7]}));
            OPC_BRANCH: imm = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
            OPC_JAL:    imm = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
            OPC_LUI:    imm = XLEN'($signed({ir[31:12], 12'b0}));
            default:    imm = XLEN'($signed(ir[31:20]));
        endcase
    end

    // LUI reuses the adder with a zero base; loads/stores add the offset
    always_comb begin
        alu_a   = (opcode == OPC_LUI) ? '0 : rs1_q;
        alu_b   = (opcode == OPC_OP) ? rs2_q : imm_q;
        alu_sel = (opcode == OPC_OP || opcode == OPC_IMM) ? f3 : 3'b000;
        alu_alt = ((opcode == OPC_OP) && ir[30]) ||
                  ((opcode == OPC_IMM) && (f3 == 3'b101) && ir[30]);
        alu     = '0;
        case (alu_sel)
            3'b000:  alu = alu_alt ? alu_a - alu_b : alu_a + alu_b;
            3'b001:  alu = alu_a << alu_b[SHW-1:0];
            3'b010:  alu = XLEN'($signed(alu_a) < $signed(alu_b));
            3'b011:  alu = XLEN'(alu_a < alu_b);
            3'b100:  alu = alu_a ^ alu_b;
            3'b101:  alu = alu_alt ? XLEN'($signed(alu_a) >>> alu_b[SHW-1:0])
                                   : alu_a >> alu_b[SHW-1:0];
            3'b110:  alu = alu_a | alu_b;
            default: alu = alu_a & alu_b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:   if (mem.imem_ready) state_nxt = S_DECODE;
            S_DECODE:  state_nxt = legal ? S_EXECUTE : S_HALT;
            S_EXECUTE: begin
                if (opcode == OPC_BRANCH)                        state_nxt = S_FETCH;
                else if (opcode == OPC_LOAD || opcode == OPC_STORE) state_nxt = S_MEM;
                else                                             state_nxt = S_WB;
            end
            S_MEM:     if (mem.dmem_ready) state_nxt = is_store ? S_FETCH : S_WB;
            S_WB:      state_nxt = S_FETCH;
            default:   state_nxt = S_HALT;
        endcase
    end

    // Requests are gated by rst so an aborted transaction drops immediately
    always_comb begin
        mem.imem_req   = !rst && (state == S_FETCH);
        mem.imem_addr  = rst ? '0 : pc[IMEM_ADDR_WIDTH+1:2];
        mem.dmem_req   = !rst && (state == S_MEM);
        mem.dmem_we    = !rst && (state == S_MEM) && is_store;
        mem.dmem_addr  = res_q[DMEM_ADDR_WIDTH+1:2];
        mem.dmem_wdata = rs2_q;
        halted         = (state == S_HALT);
        retire         = (state == S_WB) ||
                         ((state == S_EXECUTE) && (opcode == OPC_BRANCH)) ||
                         ((state == S_MEM) && is_store && mem.dmem_ready);
        debug          = regs[DBG_IDX][15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            ir    <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
            res_q <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem.imem_ready) ir <= mem.imem_rdata;
                S_DECODE: begin
                    rs1_q <= regs[rs1];
                    rs2_q <= regs[rs2];
                    imm_q <= imm;
                end
                S_EXECUTE: begin
                    if (opcode == OPC_BRANCH) begin
                        pc <= br_taken ? pc + imm_q : pc_plus4;
                    end else if (opcode == OPC_JAL) begin
                        res_q <= pc_plus4;
                        pc    <= pc + imm_q;
                    end else begin
                        res_q <= alu;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ready) begin
                        if (is_store) pc <= pc_plus4;
                        else          res_q <= mem.dmem_rdata;
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) regs[rd] <= res_q;
                    if (opcode != OPC_JAL) pc <= pc_plus4;
                end
                default: ;
            endcase
        end
    end
endmodule
